// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t : control FSM encoding (IDLE / CALC / DONE)
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/mult_step.sv
// -----------------------------------------------------------------------------
// mult_step
// One iteration of a shift-add multiply: forms the partial product
// (multiplicand AND a replicated multiplier bit), shifts it into place and
// adds it to the running 2*WIDTH accumulator. Purely combinational; the
// caller registers the result.
//
// Ports
//   mcand   : WIDTH-bit unsigned multiplicand magnitude
//   mbit    : multiplier bit selected for this iteration
//   shamt   : bit position of this iteration (0 .. WIDTH-1)
//   acc_in  : accumulator before this iteration
//   acc_out : accumulator after this iteration
// -----------------------------------------------------------------------------
module mult_step #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mbit,
  input  logic [CNT_W-1:0]   shamt,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0]   pp_row;
  logic [2*WIDTH-1:0] pp_shifted;

  assign pp_row     = mcand & {WIDTH{mbit}};
  assign pp_shifted = {{WIDTH{1'b0}}, pp_row} << shamt;
  assign acc_out    = acc_in + pp_shifted;

endmodule : mult_step

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential WIDTH x WIDTH multiplier, one partial product per clock.
// Signed operands are converted to magnitudes at accept time; the sign of the
// result is reapplied when the final accumulator value is loaded into product.
// A result appears WIDTH clock edges after the accepting edge and is held
// until the consumer takes it.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : operand pair offered
//   in_ready    : high in IDLE, block can take operands
//   a, b        : multiplicand / multiplier
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   out_valid   : high in DONE, product is valid
//   out_ready   : consumer takes the product
//   product     : 2*WIDTH-bit result
// -----------------------------------------------------------------------------
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  // Two's-complement magnitude. The most negative value maps onto
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? -u : u;
  endfunction

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mplier_shifted;
  logic               mbit;
  logic [2*WIDTH-1:0] step_sum;
  logic [2*WIDTH-1:0] final_val;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        a_load;
  logic [WIDTH-1:0]        b_load;
  logic                    neg_load;

  assign accept    = in_valid & in_ready;
  assign last_iter = (state_q == CALC) && (count_q == CNT_W'(WIDTH - 1));

  // Shift rather than index so the selector width never has to match log2(WIDTH).
  assign mplier_shifted = mplier_q >> count_q;
  assign mbit           = mplier_shifted[0];

  // Operand conditioning at accept time.
  assign a_s      = a;
  assign b_s      = b;
  assign a_load   = signed_mode ? magnitude(a_s) : a;
  assign b_load   = signed_mode ? magnitude(b_s) : b;
  assign neg_load = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  mult_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .mcand   (mcand_q),
    .mbit    (mbit),
    .shamt   (count_q),
    .acc_in  (acc_q),
    .acc_out (step_sum)
  );

  // The final product is formed from the last step's sum directly so that
  // out_valid rises on the same edge as the last accumulation.
  assign final_val = neg_q ? -step_sum : step_sum;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      product  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q  <= a_load;
            mplier_q <= b_load;
            neg_q    <= neg_load;
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        CALC: begin
          acc_q   <= step_sum;
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            product <= final_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           signed_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic prev_ov = 1'b0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer multiplication, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic m);
    longint xi, yi, pr;
    xi = m ? longint'($signed(x)) : longint'(x);
    yi = m ? longint'($signed(y)) : longint'(y);
    pr = xi * yi;
    return pr[2*W-1:0];
  endfunction

  // Offer one operand pair; returns at the negedge preceding the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                      input logic [2*W-1:0] expv, input bit chk_spacing);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      a           = x;
      b           = y;
      signed_mode = m;
      if (in_ready) begin
        e.p       = expv;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        if (chk_spacing) check("b2b_spacing", cyc + 1 - last_acc, 10);
        last_acc = cyc + 1;
        done     = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() > 0; t++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  // Monitor: latency on out_valid rise, product on each handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency", cyc - sb[0].acc_cyc, W);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_product", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("product", product, mon_e.p);
        end
      end
    end
    prev_ov = out_valid;
  end

  logic [W-1:0]   da [6] = '{8'hFF, 8'hFD, 8'h80, 8'hFF, 8'h00, 8'h00};
  logic [W-1:0]   db [6] = '{8'hFF, 8'h05, 8'h80, 8'hFF, 8'h00, 8'hAB};
  logic           dm [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [2*W-1:0] dp [6] = '{16'hFE01, 16'hFFF1, 16'h4000, 16'h0001, 16'h0000, 16'h0000};

  initial begin
    logic [W-1:0] ra, rb;
    logic         rm;
    bit           seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_after", out_valid, 0);

    // Directed vectors, one at a time
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(da[i], db[i], dm[i], dp[i], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      drain();
    end

    // Backpressure in DONE with new operands driven
    out_ready = 1'b0;
    send(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    check("hold_reached", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      in_valid    = 1'b1;
      a           = 8'($urandom);
      b           = 8'($urandom);
      signed_mode = 1'($urandom);
      #1;
      check("hold_product", product, 16'hFFF1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    drain();

    // Reset in the middle of CALC (count = 4)
    send(8'hC3, 8'h5A, 1'b0, ref_mul(8'hC3, 8'h5A, 1'b0), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_reset", seen, 0);
    send(8'd7, 8'd9, 1'b0, 16'h003F, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Back-to-back random pairs
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 1'($urandom);
      send(ra, rb, rm, ref_mul(ra, rb, rm), i > 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1): iteration counter width, derived and not overridden.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port product  output  2*WIDTH  result, two's-complement when the latched mode is signed.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready SHALL latch a, b, signed_mode, clear accumulator and counter, and go to CALC.
REQ-016 At accept in signed mode SHALL store |a|, |b| as WIDTH-bit unsigned magnitudes and latch neg = a[MSB]^b[MSB]; unsigned mode stores operands as-is with neg=0.
REQ-017 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), with no overflow.
REQ-018 CALC: each cycle SHALL add (multiplicand AND replicated multiplier bit[count]) shifted left by count to the 2*WIDTH accumulator and increment count.
REQ-019 After exactly WIDTH CALC cycles SHALL load product = neg ? -acc : acc (2*WIDTH-bit two's complement) and go to DONE.
REQ-020 out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-021 DONE: product and out_valid SHALL hold stable while out_ready=0, for any duration.
REQ-022 DONE: on out_ready=1 SHALL go to IDLE; in_ready rises on the following cycle, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-023 in_valid, a, b and signed_mode changes during CALC/DONE SHALL have no effect.
REQ-024 Zero operands SHALL still take the full WIDTH cycles; there is no early termination.
REQ-025 product SHALL hold its last value in IDLE and CALC; it is valid only while out_valid=1.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, product=0, accumulator=0, count=0.
REQ-027 Reset during CALC or DONE SHALL abandon the operation with no out_valid pulse; the first accept after release starts a clean multiply.

Structure
REQ-028 SHALL take the state enum (IDLE/CALC/DONE) from shared package mult_pkg.
REQ-029 One sub-module mult_step SHALL be instantiated: combinational partial-product AND plus 2*WIDTH adder for one iteration (array-cell equivalent).
REQ-030 All other logic (FSM, registers, sign handling) SHALL stay in shift_add_multiplier.

Verification (WIDTH=8)
REQ-031 Unsigned 255 x 255 -> product=0xFE01, out_valid 8 edges after accept.
REQ-032 Signed -3 (0xFD) x 5 -> 0xFFF1; signed -128 x -128 -> 0x4000; signed 0xFF x 0xFF -> 0x0001.
REQ-033 out_ready held low 5 cycles in DONE, with new in_valid/a/b driven -> product stable, in_ready=0, nothing accepted; release -> IDLE next cycle.
REQ-034 rst_n pulsed low at CALC count=4 -> out_valid never asserts; next 7 x 9 unsigned -> 0x003F.
REQ-035 Back-to-back random signed/unsigned pairs, in_valid and out_ready held high -> all match reference model, 10-cycle spacing.
